// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - EX/memory/writeback handshake bundle for the load/store unit
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 2
`define LSU_OPT_NONE  2'd0
`define LSU_OPT_LOAD  2'd1
`define LSU_OPT_STORE 2'd2
`define LSU_OPT_SYS   2'd3
`endif

interface riscv_lsu_if;
    logic                      in_valid;
    logic                      in_ready;
    logic [`LSU_OPT_WIDTH-1:0] lsu_opt;
    logic [2:0]                funct3;
    logic [31:0]               addr;
    logic [31:0]               wdata;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic                      mem_req_wen;
    logic [31:0]               mem_req_addr;
    logic [31:0]               mem_req_wdata;
    logic [3:0]                mem_req_wmask;
    logic                      mem_rsp_valid;
    logic [31:0]               mem_rsp_rdata;
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_rdata;
    logic                      out_err;

    modport slave (
        input  in_valid, lsu_opt, funct3, addr, wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
        output in_ready, mem_req_valid, mem_req_wen, mem_req_addr,
        output mem_req_wdata, mem_req_wmask, out_valid, out_rdata, out_err
    );

    modport master (
        output in_valid, lsu_opt, funct3, addr, wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
        input  in_ready, mem_req_valid, mem_req_wen, mem_req_addr,
        input  mem_req_wdata, mem_req_wmask, out_valid, out_rdata, out_err
    );
endinterface

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit, one memory transaction per op; LSU_MISALIGN_CHECK_EN enables misalign trapping
`ifndef LSU_OPT_WIDTH
`define LSU_OPT_WIDTH 2
`define LSU_OPT_NONE  2'd0
`define LSU_OPT_LOAD  2'd1
`define LSU_OPT_STORE 2'd2
`define LSU_OPT_SYS   2'd3
`endif

module riscv_lsu (
    input  logic        clk,
    input  logic        rst,
    riscv_lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [`LSU_OPT_WIDTH-1:0] op_q;
    logic [2:0]                funct3_q;
    logic [1:0]                lane_q;
    logic                      is_load;
    logic                      is_store;
    logic                      misaligned;
    logic [3:0]                st_mask;
    logic [31:0]               st_data;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [31:0]               ld_data;

    assign is_load  = (bus.lsu_opt == `LSU_OPT_LOAD);
    assign is_store = (bus.lsu_opt == `LSU_OPT_STORE);

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (bus.funct3)
            3'b001:  misaligned = bus.addr[0];
            3'b101:  misaligned = is_load & bus.addr[0];
            3'b010:  misaligned = |bus.addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)
                      state_nxt = ((is_load | is_store) & ~misaligned) ? REQ : DONE;
            REQ:  if (bus.mem_req_ready) state_nxt = WAIT;
            WAIT: if (bus.mem_rsp_valid) state_nxt = DONE;
            DONE: if (bus.out_ready)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so reset drops them asynchronously.
    always_comb begin
        bus.in_ready      = (state == IDLE);
        bus.mem_req_valid = (state == REQ);
        bus.out_valid     = (state == DONE);
    end

    always_comb begin
        st_mask = 4'b0000;
        st_data = bus.wdata;
        case (bus.funct3)
            3'b000: begin
                st_mask = 4'b0001 << bus.addr[1:0];
                st_data = {4{bus.wdata[7:0]}};
            end
            3'b001: begin
                st_mask = 4'b0011 << {bus.addr[1], 1'b0};
                st_data = {2{bus.wdata[15:0]}};
            end
            3'b010:  st_mask = 4'b1111;
            default: st_mask = 4'b0000;
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = bus.mem_rsp_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rsp_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rsp_rdata[23:16];
            default: ld_byte = bus.mem_rsp_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? bus.mem_rsp_rdata[31:16] : bus.mem_rsp_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = bus.mem_rsp_rdata;
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q              <= `LSU_OPT_NONE;
            funct3_q          <= 3'd0;
            lane_q            <= 2'd0;
            bus.mem_req_wen   <= 1'b0;
            bus.mem_req_addr  <= 32'd0;
            bus.mem_req_wdata <= 32'd0;
            bus.mem_req_wmask <= 4'd0;
            bus.out_rdata     <= 32'd0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                op_q          <= bus.lsu_opt;
                funct3_q      <= bus.funct3;
                lane_q        <= bus.addr[1:0];
                bus.out_rdata <= bus.addr;
                // Request fields only change when a request will actually be issued.
                if (state_nxt == REQ) begin
                    bus.mem_req_wen   <= is_store;
                    bus.mem_req_addr  <= {bus.addr[31:2], 2'b00};
                    bus.mem_req_wmask <= is_store ? st_mask : 4'b0000;
                    bus.mem_req_wdata <= is_store ? st_data : 32'd0;
                end
            end
            if (state == WAIT && bus.mem_rsp_valid)
                bus.out_rdata <= (op_q == `LSU_OPT_STORE) ? 32'd0 : ld_data;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             err_q <= 1'b0;
        else if (state == IDLE && bus.in_valid) err_q <= (is_load | is_store) & misaligned;
    end
    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit of the npc core, sitting directly downstream of instruction decode and execute. It consumes the decoded `lsu_opt` and `funct3` together with the ALU-computed effective address and the rs2 store data, runs one valid/ready memory transaction per load or store, and returns a writeback value. Non-memory operations pass straight through so writeback sees one uniform result stream.

## Interface
Parameters:
- none; widths come from `riscv_define.v` (`` `LSU_OPT_WIDTH ``, `` `LSU_OPT_NONE/LOAD/STORE/SYS ``)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation offered by EX
- in_ready  out  1  LSU can accept; high only in IDLE
- lsu_opt  in  `` `LSU_OPT_WIDTH ``  decoded LSU operation
- funct3  in  3  access size/sign
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_wen  out  1  1 = store
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wmask  out  4  byte enables; 0 for loads
- mem_rsp_valid  in  1  one-cycle response pulse, exactly one per accepted request
- mem_rsp_rdata  in  32  read word (ignored for stores)
- out_valid  out  1  result ready for writeback
- out_ready  in  1  writeback consumes result
- out_rdata  out  32  load result or pass-through addr
- out_err  out  1  misaligned access flag (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, latch lsu_opt, funct3, addr, wdata. LOAD/STORE -> REQ; NONE/SYS -> DONE with out_rdata=addr.
- REQ: mem_req_valid=1; wen/addr/wdata/wmask held stable until mem_req_ready. Handshake -> WAIT.
- WAIT: on mem_rsp_valid -> DONE; load result formatted from mem_rsp_rdata, stores give out_rdata=0. mem_rsp_valid outside WAIT is ignored.
- DONE: out_valid=1, out_rdata/out_err stable until out_ready; then -> IDLE.
- Load format, byte lane = addr[1:0], half lane = addr[1]: 000 lb sign-extend byte; 001 lh sign-extend half; 010 lw word; 100 lbu zero-extend; 101 lhu zero-extend; other funct3 -> 0.
- Store: 000 sb wmask=4'b0001<<addr[1:0], wdata byte replicated in all lanes; 001 sh wmask=4'b0011<<{addr[1],1'b0}, half replicated; 010 sw wmask=4'b1111; other funct3 -> wmask=0, request still issued.

## Timing
- Reset values: in_ready=1 (state IDLE), mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, out_valid=0, out_rdata=0, out_err=0.
- Accept at cycle 0 in IDLE. Pass-through: out_valid at cycle 1. Memory op, zero-wait memory: mem_req_valid at cycle 1, rsp at cycle 2, out_valid at cycle 3. Each stall cycle on mem_req_ready, mem_rsp_valid or out_ready adds one cycle.
- No new accept until DONE handshake completes, so there is at most one operation in flight.
- Reset asserted mid-operation: state returns to IDLE immediately and mem_req_valid drops asynchronously. A response still pending from memory is the memory's responsibility to flush.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, issue no memory request. The FSM goes IDLE -> DONE with out_err=1 and out_rdata=addr.
- Undefined: out_err is tied to 0. Misaligned half accesses use addr[1] only, and misaligned word accesses ignore addr[1:0], so a request is always issued.

## Test plan
- Reset mid-REQ (mem_req_ready=0) -> mem_req_valid=0 in the same cycle, in_ready=1, out_valid=0.
- lb at addr 0x1003, rsp 0x80FF_FF11, zero-wait memory -> mem_req_addr=0x1000, wmask=0, out_rdata=0xFFFF_FF80 at cycle 3. Same access as lbu -> 0x0000_0080.
- sh at addr 0x2002, wdata 0x1234_ABCD, mem_req_ready low for 3 cycles -> wmask=4'b1100, wdata=0xABCD_ABCD held stable for all 4 cycles, out_rdata=0.
- NONE with addr 0xDEAD_BEEF, out_ready low for 2 cycles -> no memory request, out_valid from cycle 1 held for 3 cycles, out_rdata=0xDEAD_BEEF.
- lw at 0x3002 with the macro defined -> no mem_req_valid, out_err=1, out_rdata=0x0000_3002. Without the macro -> request at 0x3000 issued, out_err=0.
- Spurious mem_rsp_valid while in IDLE and in REQ -> no state change, no out_valid.
